// File: rtl/fetcher.sv
// fetcher: instruction fetch responder for the core scheduler's FETCH/DECODE sequence.
// Optional single-entry fetch reuse tag is compiled in with FETCHER_REUSE_EN.
module fetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic [31:0]                      fetch_request_count,
    output logic [31:0]                      fetch_reuse_count,
    output logic [31:0]                      fetch_wait_cycles
);

    localparam logic [2:0] CORE_IDLE   = 3'b000;
    localparam logic [2:0] CORE_FETCH  = 3'b001;
    localparam logic [2:0] CORE_DECODE = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE     = 3'b000,
        S_FETCHING = 3'b001,
        S_FETCHED  = 3'b010
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                             valid_nxt;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_nxt;
    logic [PROGRAM_MEM_DATA_BITS-1:0] instr_nxt;
    logic [31:0]                      req_nxt;
    logic [31:0]                      wait_nxt;

    logic core_idle;
    logic core_fetch;
    logic core_decode;
    logic hit;

    assign core_idle   = (core_state == CORE_IDLE);
    assign core_fetch  = (core_state == CORE_FETCH);
    assign core_decode = (core_state == CORE_DECODE);

    assign fetcher_state = state;

`ifdef FETCHER_REUSE_EN
    logic [PROGRAM_MEM_ADDR_BITS-1:0] tag_pc;
    logic                             tag_valid;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] tag_pc_nxt;
    logic                             tag_valid_nxt;
    logic [31:0]                      reuse_q;
    logic [31:0]                      reuse_nxt;

    assign hit = tag_valid && (tag_pc == current_pc);
    assign fetch_reuse_count = reuse_q;

    // Reuse tag and reuse counter; only reset clears the tag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tag_pc    <= '0;
            tag_valid <= 1'b0;
            reuse_q   <= '0;
        end else begin
            tag_pc    <= tag_pc_nxt;
            tag_valid <= tag_valid_nxt;
            reuse_q   <= reuse_nxt;
        end
    end
`else
    assign hit = 1'b0;
    assign fetch_reuse_count = '0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a scheduler restart (core IDLE) overrides everything.
    always_comb begin
        state_nxt = state;
        if (core_idle) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (core_fetch) begin
                        state_nxt = hit ? S_FETCHED : S_FETCHING;
                    end
                end
                S_FETCHING: begin
                    if (mem_read_ready) begin
                        state_nxt = S_FETCHED;
                    end
                end
                S_FETCHED: begin
                    if (core_decode) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs, counters and tag.
    always_comb begin
        valid_nxt = mem_read_valid;
        addr_nxt  = mem_read_address;
        instr_nxt = instruction;
        req_nxt   = fetch_request_count;
        wait_nxt  = fetch_wait_cycles;
`ifdef FETCHER_REUSE_EN
        tag_pc_nxt    = tag_pc;
        tag_valid_nxt = tag_valid;
        reuse_nxt     = reuse_q;
`endif
        if (state == S_FETCHING && !mem_read_ready) begin
            wait_nxt = fetch_wait_cycles + 32'd1;
        end
        if (core_idle) begin
            valid_nxt = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (core_fetch) begin
                        if (hit) begin
`ifdef FETCHER_REUSE_EN
                            reuse_nxt = reuse_q + 32'd1;
`endif
                        end else begin
                            valid_nxt = 1'b1;
                            addr_nxt  = current_pc;
                            req_nxt   = fetch_request_count + 32'd1;
                        end
                    end
                end
                S_FETCHING: begin
                    if (mem_read_ready) begin
                        instr_nxt = mem_read_data;
                        valid_nxt = 1'b0;
`ifdef FETCHER_REUSE_EN
                        tag_pc_nxt    = mem_read_address;
                        tag_valid_nxt = 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Output and counter registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_read_valid      <= 1'b0;
            mem_read_address    <= '0;
            instruction         <= '0;
            fetch_request_count <= '0;
            fetch_wait_cycles   <= '0;
        end else begin
            mem_read_valid      <= valid_nxt;
            mem_read_address    <= addr_nxt;
            instruction         <= instr_nxt;
            fetch_request_count <= req_nxt;
            fetch_wait_cycles   <= wait_nxt;
        end
    end

endmodule

// File: tb/tb_fetcher.sv
// tb_fetcher: directed self-checking bench for fetcher.
// Expectations follow FETCHER_REUSE_EN when it is defined.
module tb_fetcher;

    logic        clk;
    logic        reset_n;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;
    logic [31:0] fetch_request_count;
    logic [31:0] fetch_reuse_count;
    logic [31:0] fetch_wait_cycles;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_req;

    fetcher dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .core_state          (core_state),
        .current_pc          (current_pc),
        .mem_read_valid      (mem_read_valid),
        .mem_read_address    (mem_read_address),
        .mem_read_ready      (mem_read_ready),
        .mem_read_data       (mem_read_data),
        .fetcher_state       (fetcher_state),
        .instruction         (instruction),
        .fetch_request_count (fetch_request_count),
        .fetch_reuse_count   (fetch_reuse_count),
        .fetch_wait_cycles   (fetch_wait_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        core_state     = 3'b000;
        current_pc     = 8'h00;
        mem_read_ready = 1'b0;
        mem_read_data  = 16'h0000;
        exp_req        = 0;
        step();
        step();
        chk("rst_state", {29'd0, fetcher_state}, 32'd0);
        chk("rst_valid", {31'd0, mem_read_valid}, 32'd0);
        chk("rst_addr", {24'd0, mem_read_address}, 32'd0);
        chk("rst_instr", {16'd0, instruction}, 32'd0);
        chk("rst_req", fetch_request_count, 32'd0);
        chk("rst_reuse", fetch_reuse_count, 32'd0);
        chk("rst_wait", fetch_wait_cycles, 32'd0);

        // Basic miss, 3 wait cycles
        reset_n    = 1'b1;
        current_pc = 8'h05;
        core_state = 3'b001;
        step();
        exp_req = 1;
        chk("miss_state", {29'd0, fetcher_state}, 32'd1);
        chk("miss_valid", {31'd0, mem_read_valid}, 32'd1);
        chk("miss_addr", {24'd0, mem_read_address}, 32'h05);
        chk("miss_req", fetch_request_count, exp_req);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("wait_state", {29'd0, fetcher_state}, 32'd1);
            chk("wait_addr", {24'd0, mem_read_address}, 32'h05);
            chk("wait_valid", {31'd0, mem_read_valid}, 32'd1);
            chk("wait_cnt", fetch_wait_cycles, i);
        end
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h9123;
        step();
        mem_read_ready = 1'b0;
        chk("resp_state", {29'd0, fetcher_state}, 32'd2);
        chk("resp_instr", {16'd0, instruction}, 32'h9123);
        chk("resp_valid", {31'd0, mem_read_valid}, 32'd0);
        chk("resp_wait", fetch_wait_cycles, 32'd3);
        chk("resp_req", fetch_request_count, exp_req);

        // FETCH held while FETCHED, then DECODE
        for (int i = 0; i < 4; i++) begin
            step();
            chk("hold_state", {29'd0, fetcher_state}, 32'd2);
            chk("hold_req", fetch_request_count, exp_req);
            chk("hold_valid", {31'd0, mem_read_valid}, 32'd0);
        end
        core_state = 3'b010;
        step();
        chk("dec_state", {29'd0, fetcher_state}, 32'd0);
        chk("dec_instr", {16'd0, instruction}, 32'h9123);

        // Reserved core_state values are ignored
        core_state = 3'b101;
        step();
        chk("rsv_state", {29'd0, fetcher_state}, 32'd0);
        chk("rsv_req", fetch_request_count, exp_req);

        // Abort: IDLE and ready in the same cycle
        current_pc = 8'h20;
        core_state = 3'b001;
        step();
        exp_req++;
        chk("abt_fetching", {29'd0, fetcher_state}, 32'd1);
        core_state     = 3'b000;
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hBEEF;
        step();
        chk("abt_state", {29'd0, fetcher_state}, 32'd0);
        chk("abt_valid", {31'd0, mem_read_valid}, 32'd0);
        chk("abt_instr", {16'd0, instruction}, 32'h9123);
        chk("abt_wait", fetch_wait_cycles, 32'd3);
        step();
        mem_read_ready = 1'b0;
        chk("late_state", {29'd0, fetcher_state}, 32'd0);
        chk("late_instr", {16'd0, instruction}, 32'h9123);

        // Reuse: pc 0x10 fetched twice
        current_pc = 8'h10;
        core_state = 3'b001;
        step();
        exp_req++;
        chk("r1_state", {29'd0, fetcher_state}, 32'd1);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h1111;
        step();
        mem_read_ready = 1'b0;
        chk("r1_instr", {16'd0, instruction}, 32'h1111);
        core_state = 3'b010;
        step();
        core_state = 3'b001;
        step();
`ifdef FETCHER_REUSE_EN
        chk("r2_state", {29'd0, fetcher_state}, 32'd2);
        chk("r2_valid", {31'd0, mem_read_valid}, 32'd0);
        chk("r2_req", fetch_request_count, exp_req);
        chk("r2_reuse", fetch_reuse_count, 32'd1);
        chk("r2_instr", {16'd0, instruction}, 32'h1111);
`else
        exp_req++;
        chk("r2_state", {29'd0, fetcher_state}, 32'd1);
        chk("r2_valid", {31'd0, mem_read_valid}, 32'd1);
        chk("r2_req", fetch_request_count, exp_req);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h1111;
        step();
        mem_read_ready = 1'b0;
        chk("r2_done", {29'd0, fetcher_state}, 32'd2);
        chk("r2_reuse", fetch_reuse_count, 32'd0);
`endif
        core_state = 3'b010;
        step();
        chk("r_idle", {29'd0, fetcher_state}, 32'd0);

        // Back-to-back, zero-wait memory
        for (int i = 0; i < 3; i++) begin
            current_pc = 8'(i);
            core_state = 3'b001;
            step();
            exp_req++;
            chk("b2b_fetching", {29'd0, fetcher_state}, 32'd1);
            chk("b2b_addr", {24'd0, mem_read_address}, i);
            mem_read_ready = 1'b1;
            mem_read_data  = 16'hA000 + 16'(i);
            step();
            mem_read_ready = 1'b0;
            chk("b2b_state", {29'd0, fetcher_state}, 32'd2);
            chk("b2b_instr", {16'd0, instruction}, 32'hA000 + i);
            core_state = 3'b010;
            step();
        end
        chk("b2b_req", fetch_request_count, exp_req);
        chk("b2b_wait", fetch_wait_cycles, 32'd3);

        // Reset in mid-FETCHING with a response present
        current_pc = 8'h33;
        core_state = 3'b001;
        step();
        chk("pre_rst_valid", {31'd0, mem_read_valid}, 32'd1);
        reset_n        = 1'b0;
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hDEAD;
        step();
        chk("mrst_state", {29'd0, fetcher_state}, 32'd0);
        chk("mrst_valid", {31'd0, mem_read_valid}, 32'd0);
        chk("mrst_addr", {24'd0, mem_read_address}, 32'd0);
        chk("mrst_instr", {16'd0, instruction}, 32'd0);
        chk("mrst_req", fetch_request_count, 32'd0);
        chk("mrst_wait", fetch_wait_cycles, 32'd0);
        chk("mrst_reuse", fetch_reuse_count, 32'd0);
        reset_n    = 1'b1;
        core_state = 3'b000;
        step();
        mem_read_ready = 1'b0;
        chk("post_state", {29'd0, fetcher_state}, 32'd0);
        chk("post_instr", {16'd0, instruction}, 32'd0);

        // Tag was invalidated: last pc 0x02 must miss
        current_pc = 8'h02;
        core_state = 3'b001;
        step();
        chk("inv_state", {29'd0, fetcher_state}, 32'd1);
        chk("inv_req", fetch_request_count, 32'd1);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h4242;
        step();
        mem_read_ready = 1'b0;
        chk("inv_instr", {16'd0, instruction}, 32'h4242);
        chk("inv_wait", fetch_wait_cycles, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
